evm_session_controller: RTL and testbench

- Sequences one polling-booth session around the voter/officer ID database: officer login, voter ID check, candidate selection, then a one-cycle vote commit strobe to the tally logic.
- Sits between the front-panel inputs (ID switches, buttons) and the ID database block.
- Drives the database mode, control and read_enable inputs plus the ID buses, and consumes its status flags.
- Rejects duplicate or invalid voters and locks the booth after repeated bad officer logins.

---
 rtl/evm_session_controller.sv | 145 ++++++++++++++
 tb/tb_evm_session_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/evm_session_controller.sv
// Polling-booth session sequencer: officer login, voter check, candidate pick, vote commit strobe.
// Optional VOTE_TIMEOUT_EN abandons a voter who makes no valid selection within VOTE_TIMEOUT cycles.
module evm_session_controller #(
  parameter int STATUS_WAIT      = 2,
  parameter int MAX_OFFICER_FAIL = 3,
  parameter int VOTE_TIMEOUT     = 255,
  parameter int NUM_CAND         = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          officer_id_in,
  input  logic                officer_login,
  input  logic [4:0]          voter_id_in,
  input  logic                voter_submit,
  input  logic [NUM_CAND-1:0] cand_btn,
  input  logic                close_session,
  input  logic                db_officer_id_status,
  input  logic                db_voter_id_status,
  input  logic [3:0]          db_valid_voter_address,
  output logic                db_mode,
  output logic                db_control,
  output logic                db_read_enable,
  output logic [4:0]          db_officer_id,
  output logic [4:0]          db_voter_id,
  output logic                vote_strobe,
  output logic [2:0]          vote_cand,
  output logic [3:0]          vote_addr,
  output logic                reject,
  output logic                locked,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    OFF_CHK   = 3'd1,
    READY     = 3'd2,
    VOTER_CHK = 3'd3,
    VOTE_WAIT = 3'd4,
    CAST      = 3'd5,
    REJECT    = 3'd6,
    LOCKED    = 3'd7
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(STATUS_WAIT - 1);
  localparam logic [2:0] FAIL_MAX  = 3'(MAX_OFFICER_FAIL);

  state_t     state_reg, state_next;
  logic [3:0] wait_cnt_reg;
  logic [2:0] fail_cnt_reg;
  logic       off_fail;
  logic       cand_single;
  logic [2:0] cand_idx;
  logic       wait_done;
`ifdef VOTE_TIMEOUT_EN
  logic [15:0] to_cnt_reg;
  logic        to_expired;
  assign to_expired = (to_cnt_reg == 16'(VOTE_TIMEOUT - 1));
`endif

  assign wait_done   = (wait_cnt_reg == 4'd0);
  assign cand_single = $onehot(cand_btn);
  assign state_o     = state_reg;

  always_comb begin
    cand_idx = 3'd0;
    for (int i = 0; i < NUM_CAND; i++)
      if (cand_btn[i]) cand_idx = 3'(i);
  end

  always_comb begin
    state_next = state_reg;
    off_fail   = 1'b0;
    case (state_reg)
      IDLE:      if (officer_login) state_next = OFF_CHK;
      OFF_CHK:   if (wait_done) begin
                   if (db_officer_id_status) state_next = READY;
                   else begin
                     off_fail   = 1'b1;
                     state_next = (fail_cnt_reg + 3'd1 >= FAIL_MAX) ? LOCKED : IDLE;
                   end
                 end
      READY:     if (close_session) state_next = IDLE;
                 else if (voter_submit) state_next = VOTER_CHK;
      VOTER_CHK: if (wait_done) state_next = db_voter_id_status ? VOTE_WAIT : REJECT;
      VOTE_WAIT: begin
                   if (cand_single) state_next = CAST;
`ifdef VOTE_TIMEOUT_EN
                   else if (to_expired) state_next = REJECT;
`endif
                 end
      CAST:      state_next = READY;
      REJECT:    state_next = READY;
      default:   state_next = LOCKED;
    endcase
  end

  // Outputs are decoded from the destination state so they are valid for the whole state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      wait_cnt_reg   <= 4'd0;
      fail_cnt_reg   <= 3'd0;
      db_mode        <= 1'b0;
      db_control     <= 1'b0;
      db_read_enable <= 1'b0;
      db_officer_id  <= 5'b00000;
      db_voter_id    <= 5'b00000;
      vote_strobe    <= 1'b0;
      vote_cand      <= 3'd0;
      vote_addr      <= 4'd0;
      reject         <= 1'b0;
      locked         <= 1'b0;
`ifdef VOTE_TIMEOUT_EN
      to_cnt_reg     <= 16'd0;
`endif
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && officer_login) db_officer_id <= officer_id_in;
      if (state_reg == READY && voter_submit && !close_session) db_voter_id <= voter_id_in;

      if ((state_next == OFF_CHK || state_next == VOTER_CHK) && state_next != state_reg)
        wait_cnt_reg <= WAIT_LOAD;
      else if (!wait_done)
        wait_cnt_reg <= wait_cnt_reg - 4'd1;

      if (state_reg == OFF_CHK && wait_done)
        fail_cnt_reg <= db_officer_id_status ? 3'd0 : fail_cnt_reg + 3'd1;
      if (state_reg == VOTER_CHK && wait_done && db_voter_id_status)
        vote_addr <= db_valid_voter_address;
      if (state_reg == VOTE_WAIT && cand_single)
        vote_cand <= cand_idx;
`ifdef VOTE_TIMEOUT_EN
      to_cnt_reg <= (state_reg == VOTE_WAIT) ? to_cnt_reg + 16'd1 : 16'd0;
`endif

      db_mode        <= (state_next != IDLE) && (state_next != LOCKED);
      db_control     <= (state_next != IDLE) && (state_next != LOCKED);
      db_read_enable <= (state_next == OFF_CHK) || (state_next == VOTER_CHK);
      vote_strobe    <= (state_next == CAST);
      reject         <= (state_next == REJECT) || off_fail;
      locked         <= (state_next == LOCKED);
    end
  end

endmodule

// File: tb/tb_evm_session_controller.sv
// Directed bench for evm_session_controller with immediate-assertion checks.
module tb_evm_session_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] officer_id_in = '0;
  logic       officer_login = 1'b0;
  logic [4:0] voter_id_in = '0;
  logic       voter_submit = 1'b0;
  logic [3:0] cand_btn = '0;
  logic       close_session = 1'b0;
  logic       db_officer_id_status = 1'b0;
  logic       db_voter_id_status = 1'b0;
  logic [3:0] db_valid_voter_address = '0;
  logic       db_mode, db_control, db_read_enable;
  logic [4:0] db_officer_id, db_voter_id;
  logic       vote_strobe, reject, locked;
  logic [2:0] vote_cand, state_o;
  logic [3:0] vote_addr;

  int checks = 0;
  int passed = 0;

  evm_session_controller #(
    .STATUS_WAIT(2), .MAX_OFFICER_FAIL(3), .VOTE_TIMEOUT(10), .NUM_CAND(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .officer_id_in(officer_id_in), .officer_login(officer_login),
    .voter_id_in(voter_id_in), .voter_submit(voter_submit),
    .cand_btn(cand_btn), .close_session(close_session),
    .db_officer_id_status(db_officer_id_status), .db_voter_id_status(db_voter_id_status),
    .db_valid_voter_address(db_valid_voter_address),
    .db_mode(db_mode), .db_control(db_control), .db_read_enable(db_read_enable),
    .db_officer_id(db_officer_id), .db_voter_id(db_voter_id),
    .vote_strobe(vote_strobe), .vote_cand(vote_cand), .vote_addr(vote_addr),
    .reject(reject), .locked(locked), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
      $display("check %s obs=%0h exp=%0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic submit_voter(input logic [4:0] id, input logic st, input logic [3:0] addr);
    voter_id_in = id; db_voter_id_status = st; db_valid_voter_address = addr;
    voter_submit = 1'b1;
    step();
    voter_submit = 1'b0;
    step();
    step();
  endtask

  initial begin
    #2;
    chk("rst_state", 8'(state_o), 8'd0);
    chk("rst_outs", 8'({db_mode, db_control, db_read_enable, vote_strobe, reject, locked}), 8'd0);
    chk("rst_ids", 8'({db_officer_id, 3'b000}) | 8'(db_voter_id), 8'd0);
    #10 rst_n = 1'b1;
    step();

    // Officer login, valid
    officer_id_in = 5'b11111; db_officer_id_status = 1'b1; officer_login = 1'b1;
    step();
    officer_login = 1'b0;
    chk("offchk_state", 8'(state_o), 8'd1);
    chk("offchk_db", 8'({db_mode, db_control, db_read_enable}), 8'b111);
    chk("offchk_id", 8'(db_officer_id), 8'h1f);
    step();
    chk("offchk_hold", 8'(state_o), 8'd1);
    step();
    chk("ready_state", 8'(state_o), 8'd2);
    chk("ready_db", 8'({db_mode, db_control, db_read_enable}), 8'b110);

    // Valid voter, candidate 2
    submit_voter(5'b00010, 1'b1, 4'd2);
    chk("vw_state", 8'(state_o), 8'd4);
    chk("voter_id", 8'(db_voter_id), 8'h02);
    cand_btn = 4'b0100;
    step();
    cand_btn = 4'b0000;
    chk("cast_state", 8'(state_o), 8'd5);
    chk("cast_strobe", 8'(vote_strobe), 8'd1);
    chk("cast_cand", 8'(vote_cand), 8'd2);
    chk("cast_addr", 8'(vote_addr), 8'd2);
    step();
    chk("post_cast_state", 8'(state_o), 8'd2);
    chk("post_cast_strobe", 8'(vote_strobe), 8'd0);

    // Same voter again, database says already voted
    submit_voter(5'b00010, 1'b0, 4'd0);
    chk("rej_state", 8'(state_o), 8'd6);
    chk("rej_pulse", 8'({reject, vote_strobe}), 8'b10);
    step();
    chk("rej_back", 8'({state_o, reject}), 8'({3'd2, 1'b0}));

`ifdef VOTE_TIMEOUT_EN
    submit_voter(5'b00011, 1'b1, 4'd3);
    chk("to_enter", 8'(state_o), 8'd4);
    for (int i = 0; i < 9; i++) step();
    chk("to_wait", 8'({state_o, reject}), 8'({3'd4, 1'b0}));
    step();
    chk("to_reject", 8'({state_o, reject, vote_strobe}), 8'({3'd6, 2'b10}));
    step();
    chk("to_back", 8'(state_o), 8'd2);
`endif

    // Two candidate buttons: ignored, then async reset mid-wait
    submit_voter(5'b00100, 1'b1, 4'd4);
    cand_btn = 4'b0110;
    step(); step(); step();
    chk("multi_btn_state", 8'(state_o), 8'd4);
    chk("multi_btn_strobe", 8'(vote_strobe), 8'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", 8'(state_o), 8'd0);
    chk("async_rst_outs", 8'({db_mode, db_control, db_read_enable, vote_strobe, reject, locked}), 8'd0);
    chk("async_rst_ids", 8'(db_voter_id) | 8'(db_officer_id), 8'd0);
    cand_btn = 4'b0000;
    #3 rst_n = 1'b1;
    step();

    // close_session beats voter_submit in the same cycle
    officer_id_in = 5'b00101; db_officer_id_status = 1'b1; officer_login = 1'b1;
    step();
    officer_login = 1'b0;
    step(); step();
    chk("relogin_state", 8'(state_o), 8'd2);
    voter_id_in = 5'b01010; voter_submit = 1'b1; close_session = 1'b1;
    step();
    voter_submit = 1'b0; close_session = 1'b0;
    chk("close_wins_state", 8'(state_o), 8'd0);
    chk("close_wins_vid", 8'(db_voter_id), 8'd0);

    // Three failed officer logins lock the booth
    db_officer_id_status = 1'b0;
    for (int k = 0; k < 3; k++) begin
      officer_id_in = 5'(k + 1); officer_login = 1'b1;
      step();
      officer_login = 1'b0;
      step(); step();
      chk($sformatf("fail%0d_reject", k), 8'(reject), 8'd1);
      chk($sformatf("fail%0d_state", k), 8'(state_o), (k == 2) ? 8'd7 : 8'd0);
      chk($sformatf("fail%0d_locked", k), 8'(locked), (k == 2) ? 8'd1 : 8'd0);
      step();
    end
    chk("locked_reject_low", 8'(reject), 8'd0);
    db_officer_id_status = 1'b1; officer_login = 1'b1;
    step();
    officer_login = 1'b0;
    step(); step();
    chk("locked_hold", 8'({state_o, locked}), 8'({3'd7, 1'b1}));
    chk("locked_db", 8'({db_mode, db_control, db_read_enable}), 8'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end
endmodule
